truth_table_scanner: RTL

//   Upstream stimulus/capture stage for 3-input combinational function blocks such as fxyz.
//   On start, walks minterm m = 0 .. 2**N_VARS-1 and drives vars_o = m to the function under test.

---
 rtl/tt_pkg.sv | 15 +
 rtl/tt_settle_timer.sv | 27 ++
 rtl/truth_table_scanner.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table scanner.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  localparam int TT_N_VARS = 3;
  localparam int TW        = 2**TT_N_VARS;
  localparam int SETTLE_W  = 4;

endpackage

// File: rtl/tt_settle_timer.sv
// Load/decrement dwell counter; expire is high whenever the count is zero.
module tt_settle_timer
  import tt_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                expire
);

  logic [SETTLE_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - SETTLE_W'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks every minterm of an N_VARS-input function, captures its truth table and
// compares it to a golden table. Define TT_SCAN_DIFF_EN to add diff_o/first_err_o.
module truth_table_scanner
  import tt_pkg::*;
#(
  parameter int N_VARS        = TT_N_VARS,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 s_i,
  input  logic [2**N_VARS-1:0] expected_i,
  output logic [N_VARS-1:0]    vars_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 valid_o,
  output logic [2**N_VARS-1:0] table_o,
  output logic                 match_o
`ifdef TT_SCAN_DIFF_EN
  ,
  output logic [2**N_VARS-1:0] diff_o,
  output logic [N_VARS-1:0]    first_err_o
`endif
);

  localparam int TBL_W = 2**N_VARS;

  state_t            state, state_nx;
  logic [N_VARS-1:0] m;
  logic [TBL_W-1:0]  exp_q;
  logic              accept, capture, finish, clear_m;
  logic              tmr_load, tmr_dec, expire, last;

  assign last   = (m == '1);
  assign vars_o = m;

  tt_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_W'(SETTLE_CYCLES - 1)),
    .dec      (tmr_dec),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    capture  = 1'b0;
    finish   = 1'b0;
    clear_m  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    busy_o   = (state != IDLE);
    case (state)
      IDLE: begin
        if (start_i) begin
          accept   = 1'b1;
          tmr_load = 1'b1;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        if (abort_i) begin
          clear_m  = 1'b1;
          state_nx = IDLE;
        end else if (expire) begin
          state_nx = SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SAMPLE: begin
        if (abort_i) begin
          clear_m  = 1'b1;
          state_nx = IDLE;
        end else begin
          capture = 1'b1;
          if (last) begin
            state_nx = DONE;
          end else begin
            tmr_load = 1'b1;
            state_nx = DRIVE;
          end
        end
      end
      DONE: begin
        // An abort landing on the DONE cycle suppresses the completion entirely.
        clear_m  = 1'b1;
        finish   = !abort_i;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    done_o = finish;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m       <= '0;
      exp_q   <= '0;
      table_o <= '0;
      valid_o <= 1'b0;
      match_o <= 1'b0;
    end else begin
      if (accept) begin
        exp_q   <= expected_i;
        table_o <= '0;
        m       <= '0;
        valid_o <= 1'b0;
        match_o <= 1'b0;
      end else if (capture) begin
        table_o[m] <= s_i;
        if (!last) begin
          m <= m + N_VARS'(1);
        end
      end else if (clear_m) begin
        m <= '0;
      end
      if (finish) begin
        valid_o <= 1'b1;
        match_o <= (table_o == exp_q);
      end
    end
  end

`ifdef TT_SCAN_DIFF_EN
  logic [TBL_W-1:0]  diff_nx;
  logic [N_VARS-1:0] first_nx;
  logic              found;

  always_comb begin
    diff_nx  = table_o ^ exp_q;
    first_nx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < TBL_W; i++) begin
      if (!found && diff_nx[i]) begin
        first_nx = N_VARS'(i);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_o      <= '0;
      first_err_o <= '0;
    end else if (finish) begin
      diff_o      <= diff_nx;
      first_err_o <= first_nx;
    end
  end
`endif

endmodule
